granule_multibank_buffer: RTL and testbench
===========================================

# granule_multibank_buffer

Parametrised N-channel ping-pong granule store for the decoder stage chain; the generalised successor to the fixed two-channel, 18-bit, 1024-deep granule buffer. Each channel owns two RAM banks: the producer stage fills the write bank while the consumer stage reads the read bank, and a common switch event swaps them. Added per channel: a write counter and a sticky underfill flag, so a switch that arrives on an incomplete granule is reported.

## Interface
- NUM_CH, 2, number of independent channels (1..8)
- DATA_W, 18, sample width in bits
- ADDR_W, 10, bank address width; bank depth = 2^ADDR_W
- GRANULE_LEN, 576, expected writes per channel per granule (1..2^ADDR_W)
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  reset; asynchronous, active-high
- buffer_switch_event  in  1  single-cycle pulse; swap read/write banks of all channels
- clear_status  in  1  single-cycle pulse; clears all underfill flags
- rd_addr  in  NUM_CH*ADDR_W  read addresses, channel c at [c*ADDR_W +: ADDR_W]
- rd_data  out  NUM_CH*DATA_W  registered read data, channel c at [c*DATA_W +: DATA_W]
- wr_en  in  NUM_CH  per-channel write enable
- wr_addr  in  NUM_CH*ADDR_W  write addresses, same packing as rd_addr
- wr_data  in  NUM_CH*DATA_W  write data, same packing as rd_data
- bank_sel  out  1  physical bank currently written (0 or 1); read bank = ~bank_sel
- wr_count  out  NUM_CH*(ADDR_W+1)  writes into current write bank since last switch
- underfill  out  NUM_CH  sticky: a switch occurred with wr_count != GRANULE_LEN

## Operation
- Storage: 2*NUM_CH simple dual-port RAMs, DATA_W x 2^ADDR_W; one write port, one registered read port each. RAM contents are not reset.
- Write: wr_en[c] high at an edge -> wr_data[c] stored at wr_addr[c] in bank bank_sel of channel c.
- Read: rd_addr[c] sampled every edge; rd_data[c] updated from bank ~bank_sel of channel c. No read enable.
- Switch: buffer_switch_event high at an edge -> bank_sel toggles at that edge. Every channel switches together.
- wr_count[c]: +1 per write edge, saturates at 2^ADDR_W. On a switch edge it loads 0. The write in that cycle belongs to the old granule and is not counted in the new one.
- Underfill check at switch edge, per channel: old = wr_count[c] + (wr_en[c] ? 1 : 0), saturated. If old != GRANULE_LEN, underfill[c] set. Overfill also sets it.
- clear_status clears all underfill bits. If a set and a clear hit the same edge, set wins.
- Writes to any address count, including repeats and addresses >= GRANULE_LEN. No dedup.

## Timing
- Reset (async assert, sync release at next edge): bank_sel=0, rd_data=0, wr_count=0, underfill=0.
- Read latency: 1 cycle, address at edge N -> rd_data valid after edge N.
- Switch edge: write and read in that cycle use the pre-switch bank_sel. Data written at edge N can be read back with rd_addr presented at edge N+1 or later, after the switch at edge N.
- bank_sel, wr_count and underfill are registered, updated at the same edge as the switch.
- Back-to-back switch pulses are legal: each toggles bank_sel, and each runs the underfill check, so it fires with count 0 unless GRANULE_LEN is 1 and a write is present.
- Reset mid-granule: counts and flags are lost and bank_sel returns to 0. RAM data survives but is treated as stale.

## Configuration
- GRANULE_BUFFER_STATUS_EN defined: wr_count and underfill logic present as described.
- Not defined: wr_count and underfill tied to 0, clear_status ignored, counters not synthesised. Bank switching and data paths are identical in both builds.

## Test plan
- Reset, NUM_CH=2: all outputs 0. Write ch0 addr 5 = 0x2AAAA, switch, read ch0 addr 5 -> 0x2AAAA one cycle later. ch1 addr 5 unaffected.
- Write same addr in both banks (0x11111 then switch then 0x22222). Read across a second switch -> 0x11111 before the switch edge, 0x22222 after.
- Write and switch in the same cycle, addr 7 = 0x3FFFF. After the switch, read addr 7 -> 0x3FFFF. wr_count=0, and the old count includes that write.
- GRANULE_LEN=576: 576 writes then switch -> underfill=0. 575 writes then switch -> underfill[c]=1. Clear pulse -> 0. Clear coincident with a failing switch -> stays 1.
- 1100 writes with ADDR_W=10 -> wr_count saturates at 1024.
- Reset asserted mid-read: rd_data goes to 0 asynchronously, bank_sel=0. With the macro undefined, wr_count and underfill stay 0 throughout all of the above.

Source files
------------

// File: rtl/granule_multibank_buffer_if.sv
// Bus bundle for granule_multibank_buffer: switch/clear pulses, per-channel write and read
// ports, and the bank/status outputs.
interface granule_multibank_buffer_if #(
   parameter int NUM_CH = 2,
   parameter int DATA_W = 18,
   parameter int ADDR_W = 10
);
   logic                         buffer_switch_event;
   logic                         clear_status;
   logic [NUM_CH*ADDR_W-1:0]     rd_addr;
   logic [NUM_CH*DATA_W-1:0]     rd_data;
   logic [NUM_CH-1:0]            wr_en;
   logic [NUM_CH*ADDR_W-1:0]     wr_addr;
   logic [NUM_CH*DATA_W-1:0]     wr_data;
   logic                         bank_sel;
   logic [NUM_CH*(ADDR_W+1)-1:0] wr_count;
   logic [NUM_CH-1:0]            underfill;

   modport master (
      output buffer_switch_event, clear_status, rd_addr, wr_en, wr_addr, wr_data,
      input  rd_data, bank_sel, wr_count, underfill
   );

   modport slave (
      input  buffer_switch_event, clear_status, rd_addr, wr_en, wr_addr, wr_data,
      output rd_data, bank_sel, wr_count, underfill
   );
endinterface

// File: rtl/granule_multibank_buffer.sv
// N-channel ping-pong granule store: each channel writes one bank while the other is read.
// Define GRANULE_BUFFER_STATUS_EN to build the per-channel write counters and underfill flags.
module granule_multibank_buffer #(
   parameter int NUM_CH      = 2,
   parameter int DATA_W      = 18,
   parameter int ADDR_W      = 10,
   parameter int GRANULE_LEN = 576
) (
   input logic                       clk,
   input logic                       rst,
   granule_multibank_buffer_if.slave bus
);
   localparam int CNT_W = ADDR_W + 1;
   localparam int DEPTH = 1 << ADDR_W;

   logic                      bank_sel;
   logic [NUM_CH*DATA_W-1:0]  rd_data_q;
   logic [NUM_CH*CNT_W-1:0]   wr_count_q;
   logic [NUM_CH-1:0]         underfill_q;

   // One bank select shared by every channel so all granules swap together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bank_sel <= 1'b0;
      end else if (bus.buffer_switch_event) begin
         bank_sel <= ~bank_sel;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DATA_W-1:0] bank_mem [2][DEPTH];
      logic [ADDR_W-1:0] wr_ptr;
      logic [ADDR_W-1:0] rd_ptr;
      logic [DATA_W-1:0] rd_q;

      assign wr_ptr = bus.wr_addr[c*ADDR_W +: ADDR_W];
      assign rd_ptr = bus.rd_addr[c*ADDR_W +: ADDR_W];

      // RAM contents are deliberately left unreset so the banks map onto block RAM.
      always_ff @(posedge clk) begin
         if (bus.wr_en[c]) begin
            bank_mem[bank_sel][wr_ptr] <= bus.wr_data[c*DATA_W +: DATA_W];
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rd_q <= '0;
         end else begin
            rd_q <= bank_mem[~bank_sel][rd_ptr];
         end
      end

      assign rd_data_q[c*DATA_W +: DATA_W] = rd_q;
   end

`ifdef GRANULE_BUFFER_STATUS_EN
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] GRAN_LEN = CNT_W'(GRANULE_LEN);

   for (genvar c = 0; c < NUM_CH; c++) begin : g_status
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] old_cnt;
      logic             flag;

      // Count as it would stand after this edge's write; the switch check uses this value.
      always_comb begin
         old_cnt = cnt;
         if (bus.wr_en[c] && (cnt != CNT_MAX)) begin
            old_cnt = cnt + CNT_W'(1);
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt  <= '0;
            flag <= 1'b0;
         end else begin
            if (bus.buffer_switch_event) begin
               cnt <= '0;
            end else begin
               cnt <= old_cnt;
            end
            if (bus.buffer_switch_event && (old_cnt != GRAN_LEN)) begin
               flag <= 1'b1;
            end else if (bus.clear_status) begin
               flag <= 1'b0;
            end
         end
      end

      assign wr_count_q[c*CNT_W +: CNT_W] = cnt;
      assign underfill_q[c]               = flag;
   end
`else
   logic unused_status;
   assign unused_status = bus.clear_status ^ (GRANULE_LEN != 0);
   assign wr_count_q    = '0;
   assign underfill_q   = '0;
`endif

   assign bus.rd_data   = rd_data_q;
   assign bus.bank_sel  = bank_sel;
   assign bus.wr_count  = wr_count_q;
   assign bus.underfill = underfill_q;
endmodule

// File: tb/tb_granule_multibank_buffer.sv
// Self-checking bench for granule_multibank_buffer: directed vector table, granule sequences,
// and randomized traffic against an array-based reference model.
`timescale 1ns/1ps
module tb_granule_multibank_buffer;
   localparam int NUM_CH      = 2;
   localparam int DATA_W      = 18;
   localparam int ADDR_W      = 10;
   localparam int GRANULE_LEN = 576;
   localparam int CNT_W       = ADDR_W + 1;
   localparam int DEPTH       = 1 << ADDR_W;
`ifdef GRANULE_BUFFER_STATUS_EN
   localparam bit STATUS_EN = 1'b1;
`else
   localparam bit STATUS_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   granule_multibank_buffer_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus();

   granule_multibank_buffer #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .GRANULE_LEN(GRANULE_LEN)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference model: plain arrays of what each bank holds plus integer counters.
   logic [DATA_W-1:0] m_mem      [NUM_CH][2][DEPTH];
   bit                m_known    [NUM_CH][2][DEPTH];
   int                m_bank;
   int                m_cnt      [NUM_CH];
   bit                m_uf       [NUM_CH];
   logic [DATA_W-1:0] m_rd       [NUM_CH];
   bit                m_rd_known [NUM_CH];

   typedef struct {
      logic              sw;
      logic              clr;
      logic              we0;
      logic [ADDR_W-1:0] wa0;
      logic [DATA_W-1:0] wd0;
      logic [ADDR_W-1:0] ra0;
      logic              chk_rd;
      logic [DATA_W-1:0] exp_rd0;
      logic              exp_bank;
      logic [CNT_W-1:0]  exp_cnt0;
      logic              exp_uf0;
   } vec_t;

   vec_t vecs [11];

   function automatic vec_t mk(input logic sw, input logic clr, input logic we0,
                               input int wa0, input int wd0, input int ra0,
                               input logic chk_rd, input int exp_rd0, input logic exp_bank,
                               input int exp_cnt0, input logic exp_uf0);
      vec_t v;
      v.sw = sw; v.clr = clr; v.we0 = we0;
      v.wa0 = ADDR_W'(wa0); v.wd0 = DATA_W'(wd0); v.ra0 = ADDR_W'(ra0);
      v.chk_rd = chk_rd; v.exp_rd0 = DATA_W'(exp_rd0); v.exp_bank = exp_bank;
      v.exp_cnt0 = CNT_W'(exp_cnt0); v.exp_uf0 = exp_uf0;
      return v;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic compare_model(input string tag);
      check_output({tag, " bank_sel"}, 32'(bus.bank_sel), 32'(m_bank));
      for (int c = 0; c < NUM_CH; c++) begin
         check_output($sformatf("%s wr_count[%0d]", tag, c),
                      32'(bus.wr_count[c*CNT_W +: CNT_W]), STATUS_EN ? 32'(m_cnt[c]) : 32'd0);
         check_output($sformatf("%s underfill[%0d]", tag, c),
                      32'(bus.underfill[c]), STATUS_EN ? 32'(m_uf[c]) : 32'd0);
         if (m_rd_known[c]) begin
            check_output($sformatf("%s rd_data[%0d]", tag, c),
                         32'(bus.rd_data[c*DATA_W +: DATA_W]), 32'(m_rd[c]));
         end
      end
   endtask

   // Drive one cycle of inputs, advance the model by the same edge, then compare.
   task automatic apply_stimulus(input logic sw, input logic clr, input logic [NUM_CH-1:0] we,
                                 input logic [NUM_CH*ADDR_W-1:0] wa,
                                 input logic [NUM_CH*DATA_W-1:0] wd,
                                 input logic [NUM_CH*ADDR_W-1:0] ra, input string tag);
      bus.buffer_switch_event = sw;
      bus.clear_status        = clr;
      bus.wr_en               = we;
      bus.wr_addr             = wa;
      bus.wr_data             = wd;
      bus.rd_addr             = ra;
      for (int c = 0; c < NUM_CH; c++) begin
         int r;
         int w;
         int old;
         r = int'(ra[c*ADDR_W +: ADDR_W]);
         w = int'(wa[c*ADDR_W +: ADDR_W]);
         m_rd_known[c] = m_known[c][1-m_bank][r];
         m_rd[c]       = m_mem[c][1-m_bank][r];
         if (we[c]) begin
            m_mem[c][m_bank][w]   = wd[c*DATA_W +: DATA_W];
            m_known[c][m_bank][w] = 1'b1;
         end
         old = m_cnt[c] + (we[c] ? 1 : 0);
         if (old > DEPTH) old = DEPTH;
         if (sw && old != GRANULE_LEN) m_uf[c] = 1'b1;
         else if (clr)                 m_uf[c] = 1'b0;
         m_cnt[c] = sw ? 0 : old;
      end
      if (sw) m_bank = 1 - m_bank;
      @(posedge clk);
      #1;
      compare_model(tag);
   endtask

   task automatic model_reset();
      m_bank = 0;
      for (int c = 0; c < NUM_CH; c++) begin
         m_cnt[c] = 0; m_uf[c] = 1'b0; m_rd[c] = '0; m_rd_known[c] = 1'b1;
      end
   endtask

   task automatic idle_inputs();
      bus.buffer_switch_event = 1'b0;
      bus.clear_status        = 1'b0;
      bus.wr_en               = '0;
      bus.wr_addr             = '0;
      bus.wr_data             = '0;
      bus.rd_addr             = '0;
   endtask

   // Write n cycles on the channels in mask, sequential addresses, random data.
   task automatic write_burst(input int n, input logic [NUM_CH-1:0] mask, input string tag);
      logic [NUM_CH*ADDR_W-1:0] wa;
      logic [NUM_CH*DATA_W-1:0] wd;
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            wa[c*ADDR_W +: ADDR_W] = ADDR_W'(i % DEPTH);
            wd[c*DATA_W +: DATA_W] = DATA_W'($urandom);
         end
         apply_stimulus(1'b0, 1'b0, mask, wa, wd, '0, tag);
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   initial begin
      vecs[0]  = mk(0, 0, 1, 5, 'h2AAAA, 5, 0, 0,       0, 1, 0);
      vecs[1]  = mk(1, 0, 0, 0, 0,       5, 0, 0,       1, 0, 1);
      vecs[2]  = mk(0, 0, 0, 0, 0,       5, 1, 'h2AAAA, 1, 0, 1);
      vecs[3]  = mk(0, 1, 1, 5, 'h11111, 5, 1, 'h2AAAA, 1, 1, 0);
      vecs[4]  = mk(1, 0, 0, 0, 0,       5, 1, 'h2AAAA, 0, 0, 1);
      vecs[5]  = mk(0, 0, 1, 5, 'h22222, 5, 1, 'h11111, 0, 1, 1);
      vecs[6]  = mk(1, 1, 0, 0, 0,       5, 1, 'h11111, 1, 0, 1);
      vecs[7]  = mk(0, 0, 0, 0, 0,       5, 1, 'h22222, 1, 0, 1);
      vecs[8]  = mk(1, 1, 1, 7, 'h3FFFF, 7, 0, 0,       0, 0, 1);
      vecs[9]  = mk(0, 0, 0, 0, 0,       7, 1, 'h3FFFF, 0, 0, 1);
      vecs[10] = mk(0, 1, 0, 0, 0,       7, 1, 'h3FFFF, 0, 0, 0);

      idle_inputs();
      model_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      compare_model("reset");

      $display("[TB] directed vector table");
      for (int i = 0; i < 11; i++) begin
         vec_t v;
         v = vecs[i];
         apply_stimulus(v.sw, v.clr, {1'b0, v.we0}, {ADDR_W'(0), v.wa0}, {DATA_W'(0), v.wd0},
                        {ADDR_W'(5), v.ra0}, $sformatf("vec%0d", i));
         check_output($sformatf("vec%0d table bank_sel", i), 32'(bus.bank_sel), 32'(v.exp_bank));
         if (v.chk_rd) begin
            check_output($sformatf("vec%0d table rd_data[0]", i),
                         32'(bus.rd_data[DATA_W-1:0]), 32'(v.exp_rd0));
         end
         check_output($sformatf("vec%0d table wr_count[0]", i),
                      32'(bus.wr_count[CNT_W-1:0]), STATUS_EN ? 32'(v.exp_cnt0) : 32'd0);
         check_output($sformatf("vec%0d table underfill[0]", i),
                      32'(bus.underfill[0]), STATUS_EN ? 32'(v.exp_uf0) : 32'd0);
      end

      $display("[TB] granule length sequences");
      apply_stimulus(1'b1, 1'b0, '0, '0, '0, '0, "fresh_switch");
      apply_stimulus(1'b0, 1'b1, '0, '0, '0, '0, "fresh_clear");
      write_burst(GRANULE_LEN - 1, 2'b11, "fill575");
      apply_stimulus(1'b1, 1'b0, 2'b11, '0, {DATA_W'(1), DATA_W'(2)}, '0, "switch_on_576th");
      check_output("full granule underfill", 32'(bus.underfill), 32'd0);
      check_output("full granule wr_count[0]", 32'(bus.wr_count[CNT_W-1:0]), 32'd0);
      write_burst(GRANULE_LEN - 1, 2'b11, "short575");
      apply_stimulus(1'b1, 1'b0, '0, '0, '0, '0, "switch_short");
      check_output("short granule underfill", 32'(bus.underfill), STATUS_EN ? 32'd3 : 32'd0);
      apply_stimulus(1'b0, 1'b1, '0, '0, '0, '0, "clear_after_short");
      check_output("cleared underfill", 32'(bus.underfill), 32'd0);
      apply_stimulus(1'b1, 1'b0, '0, '0, '0, '0, "b2b_switch_a");
      apply_stimulus(1'b1, 1'b0, '0, '0, '0, '0, "b2b_switch_b");
      check_output("back-to-back underfill", 32'(bus.underfill), STATUS_EN ? 32'd3 : 32'd0);
      apply_stimulus(1'b0, 1'b1, '0, '0, '0, '0, "clear_b2b");
      write_burst(GRANULE_LEN - 1, 2'b01, "short_ch0");
      apply_stimulus(1'b1, 1'b1, 2'b01, '0, '0, '0, "clear_with_good_switch");
      check_output("ch0 good switch with clear", 32'(bus.underfill[0]), 32'd0);
      check_output("ch1 empty switch with clear", 32'(bus.underfill[1]),
                   STATUS_EN ? 32'd1 : 32'd0);

      $display("[TB] counter saturation");
      apply_stimulus(1'b1, 1'b1, '0, '0, '0, '0, "sat_start");
      write_burst(1100, 2'b01, "sat_fill");
      check_output("saturated wr_count[0]", 32'(bus.wr_count[CNT_W-1:0]),
                   STATUS_EN ? 32'(DEPTH) : 32'd0);
      check_output("idle wr_count[1]", 32'(bus.wr_count[2*CNT_W-1:CNT_W]), 32'd0);

      $display("[TB] reset during read");
      apply_stimulus(1'b0, 1'b0, 2'b11, {ADDR_W'(9), ADDR_W'(9)},
                     {DATA_W'('h0ABCD), DATA_W'('h01234)}, '0, "pre_reset_write");
      apply_stimulus(1'b1, 1'b0, '0, '0, '0, '0, "pre_reset_switch");
      apply_stimulus(1'b0, 1'b0, '0, '0, '0, {ADDR_W'(9), ADDR_W'(9)}, "pre_reset_read");
      check_output("pre-reset rd_data[0]", 32'(bus.rd_data[DATA_W-1:0]), 32'h01234);
      #2;
      rst = 1'b1;
      #1;
      check_output("async reset rd_data", 32'(bus.rd_data), 32'd0);
      check_output("async reset bank_sel", 32'(bus.bank_sel), 32'd0);
      check_output("async reset wr_count", 32'(bus.wr_count), 32'd0);
      check_output("async reset underfill", 32'(bus.underfill), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
      compare_model("post_reset");

      $display("[TB] randomized traffic");
      for (int i = 0; i < 3000; i++) begin
         logic [NUM_CH-1:0]        we;
         logic [NUM_CH*ADDR_W-1:0] wa;
         logic [NUM_CH*DATA_W-1:0] wd;
         logic [NUM_CH*ADDR_W-1:0] ra;
         for (int c = 0; c < NUM_CH; c++) begin
            we[c]                  = ($urandom_range(0, 3) != 0);
            wa[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 31));
            wd[c*DATA_W +: DATA_W] = DATA_W'($urandom);
            ra[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 31));
         end
         apply_stimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                        we, wa, wd, ra, $sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
